seg7_symbol_capture: RTL and testbench
======================================

Name: seg7_symbol_capture

Overview:
- Receive-side counterpart of the board's 7-segment driver logic. Samples an 8-bit segment pattern in SEG bit order, `{dp,g,f,e,d,c,b,a}`, where bit0 = a.
- Filters glitches with a stability window, then decodes the pattern back to a symbol code: hex digit or status letter.
- Delivers each new symbol through a valid/ready hold register.
- Sits between a pattern source (loopback of SEG, or external display bus) and logic that consumes decoded symbols, such as the lcd debug outputs.

Parameters:
- NBITS_SEG, 8, segment pattern width (dp included).
- STABLE_CYCLES, 4, consecutive identical samples required for acceptance (legal range >= 2).
- NBITS_CNT, 8, width of the saturating error counter.

Ports:
- clk_2  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- seg_in  input  NBITS_SEG  sampled segment pattern, bit0 = a ... bit6 = g, bit7 = dp.
- sym_ready  input  1  consumer accepts the held symbol.
- sym_valid  output  1  held symbol is pending.
- sym_code  output  5  decoded symbol (`sym_t`).
- sym_dp  output  1  dp bit of the accepted pattern.
- overrun  output  1  sticky flag: a symbol was overwritten before it was consumed.
- err_count  output  NBITS_CNT  number of accepted undecodable patterns, saturating.

Behaviour:
- Reset is asynchronous, active-high. Reset values:
  - cand = 0x00, stab_cnt = 0.
  - committed code = SYM_BLANK, committed dp = 0.
  - sym_valid = 0, sym_code = SYM_BLANK, sym_dp = 0, overrun = 0, err_count = 0.
  - Reset mid-window discards the partial count; reset with a pending symbol drops it.
- Stability tracker, evaluated each rising edge:
  - seg_in != cand: cand <= seg_in, stab_cnt <= 1.
  - seg_in == cand and stab_cnt < STABLE_CYCLES: stab_cnt++.
  - Otherwise stab_cnt holds at STABLE_CYCLES (saturates).
- Accept event:
  - Occurs on the edge where stab_cnt would reach STABLE_CYCLES, i.e. stab_cnt == STABLE_CYCLES-1 and seg_in == cand.
  - Accepted pattern = cand.
  - It fires once per stable run; a held pattern does not re-accept.
- Decode of the accepted pattern bits [6:0] (dp is stripped):
  - Digits: 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9.
  - Hex letters: 0x77→A(10), 0x7C→b(11), 0x39→C(12), 0x5E→d(13), 0x79→E(14), 0x71→F(15).
  - Status letters: 0x73→SYM_P(16), 0x54→SYM_N(17), 0x5F→SYM_A_LO(18).
  - 0x00→SYM_BLANK(19).
  - Anything else→SYM_INV(31).
- Commit:
  - On an accept where (decoded code, dp) differs from the committed pair, the committed pair updates.
  - sym_code and sym_dp are loaded in the same edge, and sym_valid <= 1.
  - An accept equal to the committed pair causes no event.
- Error counting: every accept decoding to SYM_INV increments err_count, saturating at all-ones. This applies even when no commit occurs.
- Latency: a pattern first sampled at edge t and held produces sym_valid = 1 after edge t+STABLE_CYCLES-1, i.e. on its STABLE_CYCLES-th sampling edge.
- Handshake:
  - sym_valid stays high and sym_code/sym_dp stay stable until an edge with sym_valid && sym_ready; then sym_valid <= 0.
  - sym_ready with sym_valid = 0 is ignored.
- Simultaneous handshake and commit on the same edge: new data loads, sym_valid stays 1, no overrun.
- Commit while sym_valid && !sym_ready: the new data overwrites, sym_valid stays 1, and overrun <= 1. overrun clears only on reset.

Decomposition:
- Package `seg7_pkg` holds:
  - Segment constants matching the existing display encodings: LETRA_A/F/P, NIVEL_*/DESCALIBRADO patterns, and digit patterns 0–9.
  - `typedef enum logic [4:0] sym_t` with SYM_0..SYM_F = 0..15, SYM_P = 16, SYM_N = 17, SYM_A_LO = 18, SYM_BLANK = 19, SYM_INV = 31.
- One combinational sub-module `seg7_decode` (pattern[6:0] → `sym_t`), reusable by other blocks.
- Tracker, commit and handshake logic live in `seg7_symbol_capture`.

Test Plan:
- Reset check: assert reset asynchronously mid-clock with arbitrary seg_in → all outputs 0 / SYM_BLANK immediately. Hold 0x00 for 10 cycles after release → sym_valid stays 0.
- Clean digit: seg_in = 0x3F from edge t, sym_ready = 0 → sym_valid = 1, sym_code = 0, sym_dp = 0 after edge t+3. Raise sym_ready one cycle → sym_valid = 0 next edge. Keep 0x3F held → no new event.
- Glitch rejection: 0x06 for 3 cycles, then 0x5B held → no event for 0x06. sym_code = 2 after the 4th 0x5B edge. Alternating 0x06/0x07 every cycle → no events.
- Letters and invalid patterns:
  - 0x77 stable → SYM_A (10).
  - 0x73 stable → 16.
  - 0x01 stable → SYM_INV (31), err_count = 1.
  - 0x00 then 0x01 stable again → err_count = 2.
- Overrun and simultaneous events:
  - sym_ready = 0; commit 0x77, then 0x71 → sym_code = 15, overrun = 1.
  - Separately, sym_ready = 1 on the exact edge a new commit lands → sym_valid stays 1, overrun stays 0.
- dp and reset mid-window:
  - 0x3F accepted, then 0xBF stable → new event, code 0, sym_dp = 1.
  - Reset asserted with stab_cnt = 2 → after release, the pattern needs a full 4 edges again.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: segment pattern constants and symbol codes shared by the seven-segment capture blocks
package seg7_pkg;
  localparam logic [6:0] LETRA_A = 7'h77;
  localparam logic [6:0] LETRA_F = 7'h71;
  localparam logic [6:0] LETRA_P = 7'h73;
  localparam logic [6:0] NIVEL_N = 7'h54;
  localparam logic [6:0] NIVEL_A_LO = 7'h5F;
  localparam logic [6:0] DESCALIBRADO = 7'h40;
  localparam logic [6:0] SEG_DIGIT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  typedef enum logic [4:0] {
    SYM_0 = 5'd0, SYM_1, SYM_2, SYM_3, SYM_4, SYM_5, SYM_6, SYM_7,
    SYM_8, SYM_9, SYM_A, SYM_B, SYM_C, SYM_D, SYM_E, SYM_F,
    SYM_P = 5'd16, SYM_N = 5'd17, SYM_A_LO = 5'd18, SYM_BLANK = 5'd19,
    SYM_INV = 5'd31
  } sym_t;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: maps a dp-stripped segment pattern {g..a} to its symbol code
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat,
  output sym_t       sym
);
  // pure lookup; anything not drawn by the display encoder is invalid
  always_comb begin
    case (pat)
      SEG_DIGIT[0]: sym = SYM_0;
      SEG_DIGIT[1]: sym = SYM_1;
      SEG_DIGIT[2]: sym = SYM_2;
      SEG_DIGIT[3]: sym = SYM_3;
      SEG_DIGIT[4]: sym = SYM_4;
      SEG_DIGIT[5]: sym = SYM_5;
      SEG_DIGIT[6]: sym = SYM_6;
      SEG_DIGIT[7]: sym = SYM_7;
      SEG_DIGIT[8]: sym = SYM_8;
      SEG_DIGIT[9]: sym = SYM_9;
      LETRA_A:      sym = SYM_A;
      7'h7C:        sym = SYM_B;
      7'h39:        sym = SYM_C;
      7'h5E:        sym = SYM_D;
      7'h79:        sym = SYM_E;
      LETRA_F:      sym = SYM_F;
      LETRA_P:      sym = SYM_P;
      NIVEL_N:      sym = SYM_N;
      NIVEL_A_LO:   sym = SYM_A_LO;
      7'h00:        sym = SYM_BLANK;
      default:      sym = SYM_INV;
    endcase
  end
endmodule

// File: rtl/seg7_symbol_capture.sv
// seg7_symbol_capture: debounces a sampled segment bus, decodes it and hands new symbols out via valid/ready
module seg7_symbol_capture
  import seg7_pkg::*;
#(
  parameter int NBITS_SEG     = 8,
  parameter int STABLE_CYCLES = 4,
  parameter int NBITS_CNT     = 8
) (
  input  logic                 clk_2,
  input  logic                 reset,
  input  logic [NBITS_SEG-1:0] seg_in,
  input  logic                 sym_ready,
  output logic                 sym_valid,
  output logic [4:0]           sym_code,
  output logic                 sym_dp,
  output logic                 overrun,
  output logic [NBITS_CNT-1:0] err_count
);
  localparam int W = $clog2(STABLE_CYCLES + 1);
  localparam logic [W-1:0] FULL = W'(STABLE_CYCLES);
  logic [NBITS_SEG-1:0] cand_q, cand_d;
  logic [W-1:0]         stab_q, stab_d;
  sym_t                 code_q, code_d, dec;
  logic                 dp_q, dp_d, valid_q, valid_d, ovr_q, ovr_d;
  logic [NBITS_CNT-1:0] err_q, err_d;
  logic                 same, accept, commit, cand_dp;
  seg7_decode u_decode (.pat(cand_q[6:0]), .sym(dec));
  // the output pair doubles as the committed pair: both only ever change together on a commit
  always_comb begin
    cand_dp = cand_q[NBITS_SEG-1];
    same    = seg_in == cand_q;
    accept  = same && stab_q == FULL - 1'b1;
    commit  = accept && {dec, cand_dp} != {code_q, dp_q};
    cand_d  = seg_in;
    stab_d  = !same ? W'(1) : stab_q == FULL ? FULL : stab_q + 1'b1;
    code_d  = commit ? dec : code_q;
    dp_d    = commit ? cand_dp : dp_q;
    valid_d = commit | (valid_q & ~sym_ready);
    ovr_d   = ovr_q | (commit & valid_q & ~sym_ready);
    err_d   = (accept && dec == SYM_INV && ~&err_q) ? err_q + 1'b1 : err_q;
  end
  // state registers; reset discards any partial window and any pending symbol
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      cand_q  <= '0;
      stab_q  <= '0;
      code_q  <= SYM_BLANK;
      dp_q    <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      cand_q  <= cand_d;
      stab_q  <= stab_d;
      code_q  <= code_d;
      dp_q    <= dp_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      err_q   <= err_d;
    end
  end
  assign sym_valid = valid_q;
  assign sym_code  = code_q;
  assign sym_dp    = dp_q;
  assign overrun   = ovr_q;
  assign err_count = err_q;
endmodule

// File: tb/tb_seg7_symbol_capture.sv
// tb_seg7_symbol_capture: directed plus random checks against a sample-history reference model
module tb_seg7_symbol_capture;
  logic       clk_2 = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] seg_in = 8'h00;
  logic       sym_ready = 1'b0;
  logic       sym_valid, sym_dp, overrun;
  logic [4:0] sym_code;
  logic [7:0] err_count;
  int total = 0, bad = 0;
  logic [7:0] hist [$];
  logic [4:0] m_code;
  logic       m_dp, m_valid, m_ovr;
  int         m_err;
  logic [6:0] pats [20] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F,
                            7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h73, 7'h54, 7'h5F, 7'h00};

  seg7_symbol_capture dut (
    .clk_2(clk_2), .reset(reset), .seg_in(seg_in), .sym_ready(sym_ready),
    .sym_valid(sym_valid), .sym_code(sym_code), .sym_dp(sym_dp),
    .overrun(overrun), .err_count(err_count)
  );

  always #5 clk_2 = ~clk_2;

  function automatic logic [4:0] ref_dec(input logic [6:0] p);
    for (int i = 0; i < 20; i++) if (pats[i] == p) return 5'(i);
    return 5'd31;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_code = 5'd19; m_dp = 1'b0; m_valid = 1'b0; m_ovr = 1'b0; m_err = 0;
  endtask

  // accept when the last four samples since reset match and the one before (if any) differs
  task automatic model_step(input logic [7:0] s, input logic r);
    int n;
    logic acc;
    logic [4:0] c;
    hist.push_back(s);
    if (hist.size() > 5) void'(hist.pop_front());
    n = hist.size();
    acc = n >= 4 && hist[n-2] == s && hist[n-3] == s && hist[n-4] == s && (n == 4 || hist[0] != s);
    c = ref_dec(s[6:0]);
    if (acc && c == 5'd31 && m_err < 255) m_err++;
    if (acc && {c, s[7]} != {m_code, m_dp}) begin
      if (m_valid && !r) m_ovr = 1'b1;
      m_code = c; m_dp = s[7]; m_valid = 1'b1;
    end else if (m_valid && r) m_valid = 1'b0;
  endtask

  task automatic check_all();
    chk("valid", 32'(sym_valid), 32'(m_valid));
    chk("code", 32'(sym_code), 32'(m_code));
    chk("dp", 32'(sym_dp), 32'(m_dp));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("err", 32'(err_count), 32'(m_err));
  endtask

  task automatic cyc(input logic [7:0] s, input logic r);
    seg_in = s; sym_ready = r;
    @(posedge clk_2);
    model_step(s, r);
    #1;
    check_all();
  endtask

  task automatic hold(input logic [7:0] s, input int n, input logic r);
    repeat (n) cyc(s, r);
  endtask

  task automatic do_reset();
    @(negedge clk_2);
    #1 reset = 1'b1;
    #1;
    model_reset();
    chk("rst_valid", 32'(sym_valid), 32'd0);
    chk("rst_code", 32'(sym_code), 32'd19);
    chk("rst_dp", 32'(sym_dp), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [7:0] p;
    int len;
    model_reset();
    seg_in = 8'($urandom);
    do_reset();
    hold(8'h00, 10, 1'b0);
    chk("idle_valid", 32'(sym_valid), 32'd0);
    hold(8'h3F, 3, 1'b0);
    chk("lat_early", 32'(sym_valid), 32'd0);
    cyc(8'h3F, 1'b0);
    chk("clean_valid", 32'(sym_valid), 32'd1);
    chk("clean_code", 32'(sym_code), 32'd0);
    cyc(8'h3F, 1'b1);
    chk("consumed", 32'(sym_valid), 32'd0);
    hold(8'h3F, 6, 1'b0);
    chk("no_reaccept", 32'(sym_valid), 32'd0);
    hold(8'h06, 3, 1'b0);
    hold(8'h5B, 3, 1'b0);
    chk("glitch_none", 32'(sym_valid), 32'd0);
    cyc(8'h5B, 1'b0);
    chk("glitch_code", 32'(sym_code), 32'd2);
    cyc(8'h5B, 1'b1);
    for (int i = 0; i < 10; i++) cyc(i[0] ? 8'h07 : 8'h06, 1'b0);
    chk("alt_none", 32'(sym_valid), 32'd0);
    hold(8'h77, 4, 1'b0);
    chk("letter_a", 32'(sym_code), 32'd10);
    cyc(8'h77, 1'b1);
    hold(8'h73, 4, 1'b0);
    chk("letter_p", 32'(sym_code), 32'd16);
    cyc(8'h73, 1'b1);
    hold(8'h01, 4, 1'b0);
    chk("inv_code", 32'(sym_code), 32'd31);
    chk("inv_err1", 32'(err_count), 32'd1);
    cyc(8'h01, 1'b1);
    hold(8'h00, 4, 1'b1);
    hold(8'h01, 4, 1'b1);
    chk("inv_err2", 32'(err_count), 32'd2);
    do_reset();
    hold(8'h77, 4, 1'b0);
    hold(8'h71, 4, 1'b0);
    chk("ovr_code", 32'(sym_code), 32'd15);
    chk("ovr_flag", 32'(overrun), 32'd1);
    do_reset();
    hold(8'h77, 4, 1'b0);
    hold(8'h71, 3, 1'b0);
    cyc(8'h71, 1'b1);
    chk("simul_valid", 32'(sym_valid), 32'd1);
    chk("simul_ovr", 32'(overrun), 32'd0);
    cyc(8'h71, 1'b1);
    hold(8'h3F, 4, 1'b0);
    cyc(8'h3F, 1'b1);
    hold(8'hBF, 4, 1'b0);
    chk("dp_code", 32'(sym_code), 32'd0);
    chk("dp_bit", 32'(sym_dp), 32'd1);
    chk("dp_valid", 32'(sym_valid), 32'd1);
    hold(8'h06, 2, 1'b0);
    do_reset();
    hold(8'h06, 3, 1'b0);
    chk("rstwin_early", 32'(sym_valid), 32'd0);
    cyc(8'h06, 1'b0);
    chk("rstwin_valid", 32'(sym_valid), 32'd1);
    chk("rstwin_code", 32'(sym_code), 32'd1);
    for (int k = 0; k < 400; k++) begin
      p = ($urandom_range(0, 9) < 7) ? {1'($urandom), pats[$urandom_range(0, 19)]} : 8'($urandom);
      len = $urandom_range(1, 6);
      for (int j = 0; j < len; j++) cyc(p, $urandom_range(0, 3) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
